serial_adder_ctrl: RTL and testbench

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_adder_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl
//
// Purpose:
//   Bit-serial adder with a small IDLE/ADD/DONE controller. Operands are
//   captured on an accepted start, then one bit is added per clock (LSB
//   first) through a full-adder slice built from two half adders. After
//   WIDTH add cycles the result and carry-out are registered and a
//   single-cycle done pulse is raised.
//
// Ports:
//   clk    in   1      sole clock, rising edge
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      operation request, accepted only while ready=1
//   a      in   WIDTH  operand A, captured on start acceptance
//   b      in   WIDTH  operand B, captured on start acceptance
//   sub    in   1      (only with SERIAL_ADDER_SUB_EN) 1 = compute a - b
//   ready  out  1      high in IDLE
//   busy   out  1      high in ADD
//   done   out  1      one-cycle pulse in DONE
//   sum    out  WIDTH  registered result of the last completed operation
//   cout   out  1      registered carry-out (with sub: 1 = no borrow)
//
// Configuration:
//   SERIAL_ADDER_SUB_EN  when defined, adds the sub port and subtraction
//                        via a + ~b + 1.
// ---------------------------------------------------------------------------

module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  assign s = x ^ y;
  assign c = x & y;

endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             op_sub;
  logic [WIDTH-1:0] b_in;
  logic             last_bit;
  logic             accept;

  logic             ha1_s;
  logic             ha1_c;
  logic             bit_sum;
  logic             ha2_c;
  logic             bit_carry;

`ifdef SERIAL_ADDER_SUB_EN
  assign op_sub = sub;
`else
  assign op_sub = 1'b0;
`endif

  // Subtraction stores ~b so the slice always adds; the +1 comes from the
  // carry register being preset to 1 at capture.
  assign b_in     = op_sub ? ~b : b;
  assign last_bit = (cnt == LAST);
  assign accept   = (state == IDLE) && start;

  half_adder u_ha1 (
    .x (a_sh[0]),
    .y (b_sh[0]),
    .s (ha1_s),
    .c (ha1_c)
  );

  half_adder u_ha2 (
    .x (ha1_s),
    .y (carry),
    .s (bit_sum),
    .c (ha2_c)
  );

  assign bit_carry = ha1_c | ha2_c;

  // State register; reset forces IDLE immediately, which also drops busy
  // and done since both are decoded straight from the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs. Starts outside IDLE fall through the
  // default hold and are simply dropped, never queued.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          state_nxt = ADD;
        end
      end
      ADD: begin
        busy = 1'b1;
        if (last_bit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Serial datapath. The result register fills from the MSB side so after
  // WIDTH shifts bit 0 of the answer sits in bit 0. On the final add edge
  // the visible sum is taken from the shift value including the bit being
  // produced right now, so sum/cout only ever change when entering DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      if (accept) begin
        a_sh   <= a;
        b_sh   <= b_in;
        res_sh <= '0;
        carry  <= op_sub;
        cnt    <= '0;
      end else if (state == ADD) begin
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        res_sh <= {bit_sum, res_sh[WIDTH-1:1]};
        carry  <= bit_carry;
        cnt    <= cnt + 1'b1;
        if (last_bit) begin
          sum  <= {bit_sum, res_sh[WIDTH-1:1]};
          cout <= bit_carry;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_adder_ctrl
//
// Purpose:
//   Self-checking bench for serial_adder_ctrl at WIDTH=8. Expected results
//   are pushed to a scoreboard queue when a start is driven and popped when
//   the DUT raises done. Covers reset state, a vector table, held/ignored
//   start during an operation, asynchronous reset abort and random sums.
//   With SERIAL_ADDER_SUB_EN defined it also drives sub and checks
//   subtraction.
// ---------------------------------------------------------------------------

module tb_serial_adder_ctrl;

  localparam int WIDTH = 8;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
`ifdef SERIAL_ADDER_SUB_EN
  logic       sub;
`endif
  logic       ready;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_sum;
    logic       exp_cout;
  } vec_t;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
  } exp_t;

  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;

  logic [7:0] last_sum  = 8'h00;
  logic       last_cout = 1'b0;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  // Free-running 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against the bench's expectation
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  // Advance one clock and settle just past the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for the controller to be able to accept a start
  task automatic waitReady();
    for (int i = 0; i < 40 && !ready; i++) tick();
    checkOutput("ready_before_start", 32'(ready), 32'd1);
  endtask

  // Drive one operation, optionally holding start high with junk operands
  // through the whole ADD phase, then check latency, result and the pulse
  task automatic applyStimulus(input logic [7:0] va, input logic [7:0] vb,
                               input logic vsub, input logic hold,
                               input logic [7:0] exp_sum, input logic exp_cout);
    exp_t e;
    int   busy_cycles;
    bit   seen_done;
    waitReady();
    a     = va;
    b     = vb;
    start = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
    sub   = vsub;
`endif
    e.sum  = exp_sum;
    e.cout = exp_cout;
    sb_q.push_back(e);
    tick();
    if (hold) begin
      a = 8'hFF;
      b = 8'hFF;
    end else begin
      start = 1'b0;
      a     = ~va;
      b     = ~vb;
`ifdef SERIAL_ADDER_SUB_EN
      sub   = ~vsub;
`endif
    end
    busy_cycles = 0;
    seen_done   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        seen_done = 1'b1;
        break;
      end
      if (busy) busy_cycles++;
      if (i == 3) begin
        checkOutput("sum_hold_during_add", 32'(sum), 32'(last_sum));
        checkOutput("cout_hold_during_add", 32'(cout), 32'(last_cout));
      end
      tick();
    end
    start = 1'b0;
    checkOutput("done_seen", 32'(seen_done), 32'd1);
    checkOutput("busy_cycles", 32'(busy_cycles), 32'(WIDTH));
    if (seen_done && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checkOutput("sum", 32'(sum), 32'(e.sum));
      checkOutput("cout", 32'(cout), 32'(e.cout));
      last_sum  = e.sum;
      last_cout = e.cout;
    end
    tick();
    checkOutput("done_one_cycle", 32'(done), 32'd0);
    checkOutput("ready_after_done", 32'(ready), 32'd1);
    if (hold) begin
      tick();
      checkOutput("no_queued_start", 32'(busy), 32'd0);
    end
  endtask

  // Main sequence
  initial begin
    vec_t       vecs[6];
    logic [7:0] ra;
    logic [7:0] rb;
    logic [8:0] full;
    int         done_count;

    vecs[0] = '{8'h00, 8'h00, 8'h00, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[2] = '{8'hA5, 8'h5A, 8'hFF, 1'b0};
    vecs[3] = '{8'h80, 8'h80, 8'h00, 1'b1};
    vecs[4] = '{8'h7F, 8'h01, 8'h80, 1'b0};
    vecs[5] = '{8'h3C, 8'hC3, 8'hFF, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
`ifdef SERIAL_ADDER_SUB_EN
    sub   = 1'b0;
`endif

    #12;
    checkOutput("reset_ready", 32'(ready), 32'd1);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_sum", 32'(sum), 32'd0);
    checkOutput("reset_cout", 32'(cout), 32'd0);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, 1'b0, 1'b0, vecs[i].exp_sum, vecs[i].exp_cout);
    end

    applyStimulus(8'h12, 8'h34, 1'b0, 1'b1, 8'h46, 1'b0);

    // Abort an operation with an asynchronous reset mid-ADD
    waitReady();
    a     = 8'h0F;
    b     = 8'h01;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checkOutput("busy_before_abort", 32'(busy), 32'd1);
    checkOutput("sum_before_abort", 32'(sum), 32'(last_sum));
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_sum", 32'(sum), 32'd0);
    checkOutput("abort_cout", 32'(cout), 32'd0);
    checkOutput("abort_ready", 32'(ready), 32'd1);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    #2;
    rst_n     = 1'b1;
    last_sum  = 8'h00;
    last_cout = 1'b0;
    done_count = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) done_count++;
    end
    checkOutput("no_done_after_abort", 32'(done_count), 32'd0);
    checkOutput("sum_after_abort", 32'(sum), 32'd0);
    checkOutput("ready_after_abort", 32'(ready), 32'd1);

    for (int i = 0; i < 4; i++) begin
      ra   = 8'($urandom_range(0, 255));
      rb   = 8'($urandom_range(0, 255));
      full = {1'b0, ra} + {1'b0, rb};
      applyStimulus(ra, rb, 1'b0, 1'b0, full[7:0], full[8]);
    end

`ifdef SERIAL_ADDER_SUB_EN
    applyStimulus(8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b0);
    applyStimulus(8'h07, 8'h05, 1'b1, 1'b0, 8'h02, 1'b1);
`endif

    checkOutput("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
